// File: rtl/dbfs_converter_udiv_42ns_4ns_seq.sv
// Sequential radix-2 restoring divider (quot = din0 / din1, rem = din0 % din1); DBFS_UDIV_DIV0_FLAG_EN adds a div0 output.
// Result valid din0_WIDTH+1 edges after accept; one division in flight, result held in DONE until dout_rdy.
module dbfs_converter_udiv_42ns_4ns_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 42,
  parameter int din1_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem
`ifdef DBFS_UDIV_DIV0_FLAG_EN
  ,
  output logic                  div0
`endif
);

  localparam int CW = $clog2(din0_WIDTH + 1);

  if (ID < 0) begin : g_id_range
    $error("ID must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [din0_WIDTH-1:0] dvd;     // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [din1_WIDTH-1:0] dsr;
  logic [din1_WIDTH:0]   prem;
  logic                  div0_r;
  logic [din1_WIDTH:0]   trial;
  logic                  fits;

  assign trial = {prem[din1_WIDTH-1:0], dvd[din0_WIDTH-1]};
  assign fits  = (trial >= {1'b0, dsr});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_rdy   = 1'b0;
    dout_vld  = 1'b0;
    case (state)
      IDLE: begin
        din_rdy = 1'b1;
        if (din_vld) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        dout_vld = 1'b1;
        if (dout_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cnt counts the din0_WIDTH iterations; the edge at cnt==0 publishes the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      prem   <= '0;
      div0_r <= 1'b0;
      quot   <= '0;
      rem    <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (din_vld) begin
            dvd    <= din0;
            dsr    <= din1;
            div0_r <= (din1 == '0);
            prem   <= '0;
            cnt    <= CW'(din0_WIDTH);
          end
        end
        CALC: begin
          if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            dvd  <= {dvd[din0_WIDTH-2:0], fits};
            prem <= fits ? (trial - {1'b0, dsr}) : trial;
          end else begin
            // With a zero divisor every step subtracts nothing, so prem already
            // holds the low dividend bits; only the quotient needs forcing.
            quot <= div0_r ? '1 : dvd;
            rem  <= prem[din1_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DBFS_UDIV_DIV0_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div0 <= 1'b0;
    end else if (ce && state == CALC && cnt == '0) begin
      div0 <= div0_r;
    end
  end
`endif

endmodule

// File: tb/tb_dbfs_converter_udiv_42ns_4ns_seq.sv
// Self-checking bench for the sequential divider: vector table, hand-written corner sequences, random vs. model.
module tb_dbfs_converter_udiv_42ns_4ns_seq;

  localparam int W0 = 42;
  localparam int W1 = 4;

  logic          clk;
  logic          reset;
  logic          ce;
  logic          din_vld;
  logic          din_rdy;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          dout_vld;
  logic          dout_rdy;
  logic [W0-1:0] quot;
  logic [W1-1:0] rem;
`ifdef DBFS_UDIV_DIV0_FLAG_EN
  logic          div0;
`endif

  dbfs_converter_udiv_42ns_4ns_seq #(.ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1)) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .din0     (din0),
    .din1     (din1),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .quot     (quot),
    .rem      (rem)
`ifdef DBFS_UDIV_DIV0_FLAG_EN
    ,
    .div0     (div0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [W0-1:0] q;
    logic [W1-1:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer division, divide-by-zero gives all-ones and the low dividend bits.
  function automatic void ref_div(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                  output logic [W0-1:0] q, output logic [W1-1:0] r);
    logic [W0-1:0] m;
    if (b == '0) begin
      q = '1;
      r = a[W1-1:0];
    end else begin
      q = a / W0'(b);
      m = a % W0'(b);
      r = m[W1-1:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W0-1:0] a, input logic [W1-1:0] b);
    int n;
    n = 0;
    while (!din_rdy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("din_rdy_timeout", 64'(din_rdy), 64'd1);
    din0    = a;
    din1    = b;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!dout_vld && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W0-1:0] eq;
    logic [W1-1:0] er;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic [W0-1:0] q_hold;
    logic [W1-1:0] r_hold;
    int bad_stable;

    vecs[0] = '{42'd1000, 4'd7, 42'd142, 4'd6};
    vecs[1] = '{42'h3FF_FFFF_FFFF, 4'd15, 42'd293203100740, 4'd3};
    vecs[2] = '{42'd5, 4'd9, 42'd0, 4'd5};
    vecs[3] = '{42'h3_FFFF_FFF5, 4'd0, 42'h3FF_FFFF_FFFF, 4'd5};
    vecs[4] = '{42'd12, 4'd3, 42'd4, 4'd0};
    vecs[5] = '{42'd100, 4'd10, 42'd10, 4'd0};
    vecs[6] = '{42'd0, 4'd1, 42'd0, 4'd0};
    vecs[7] = '{42'h3FF_FFFF_FFFF, 4'd1, 42'h3FF_FFFF_FFFF, 4'd0};
    vecs[8] = '{42'd15014, 4'd15, 42'd1000, 4'd14};
    vecs[9] = '{42'd6, 4'd7, 42'd0, 4'd6};

    reset    = 1'b1;
    ce       = 1'b1;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    din0     = '0;
    din1     = '0;
    #12;
    check("reset_din_rdy", 64'(din_rdy), 64'd1);
    check("reset_dout_vld", 64'(dout_vld), 64'd0);
    check("reset_quot", 64'(quot), 64'd0);
    check("reset_rem", 64'(rem), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table vectors, full handshake with dout_rdy held high
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd43);
      check($sformatf("vec%0d_quot", i), 64'(quot), 64'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), 64'(rem), 64'(vecs[i].r));
      check($sformatf("vec%0d_din_rdy_in_done", i), 64'(din_rdy), 64'd0);
      tick();
      check($sformatf("vec%0d_release_vld", i), 64'(dout_vld), 64'd0);
      check($sformatf("vec%0d_release_rdy", i), 64'(din_rdy), 64'd1);
    end

`ifdef DBFS_UDIV_DIV0_FLAG_EN
    start_op(42'h3_FFFF_FFF5, 4'd0);
    wait_done(lat);
    check("div0_flag_set", 64'(div0), 64'd1);
    check("div0_quot", 64'(quot), 64'h3FF_FFFF_FFFF);
    tick();
    start_op(42'd12, 4'd3);
    wait_done(lat);
    check("div0_flag_clear", 64'(div0), 64'd0);
    check("div0_next_quot", 64'(quot), 64'd4);
    check("div0_next_rem", 64'(rem), 64'd0);
    tick();
`endif

    // Backpressure: result held for 20 cycles, new operands ignored
    dout_rdy = 1'b0;
    start_op(42'd1000, 4'd7);
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'd43);
    q_hold     = quot;
    r_hold     = rem;
    bad_stable = 0;
    din0       = 42'd12;
    din1       = 4'd3;
    din_vld    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dout_vld !== 1'b1 || din_rdy !== 1'b0 || quot !== q_hold || rem !== r_hold) bad_stable++;
    end
    check("bp_stable_cycles_bad", 64'(bad_stable), 64'd0);
    check("bp_quot", 64'(quot), 64'd142);
    check("bp_rem", 64'(rem), 64'd6);
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    tick();
    check("bp_release_vld", 64'(dout_vld), 64'd0);
    check("bp_release_rdy", 64'(din_rdy), 64'd1);

    // ce low for 10 cycles during CALC stretches latency by exactly 10
    start_op(42'd1000, 4'd7);
    repeat (5) tick();
    ce = 1'b0;
    repeat (10) tick();
    check("ce_hold_no_vld", 64'(dout_vld), 64'd0);
    ce = 1'b1;
    wait_done(lat);
    check("ce_latency", 64'(lat + 15), 64'd53);
    check("ce_quot", 64'(quot), 64'd142);
    check("ce_rem", 64'(rem), 64'd6);
    tick();

    // Asynchronous reset mid-calculation, then a clean division
    start_op(42'd1000, 4'd7);
    repeat (20) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_dout_vld", 64'(dout_vld), 64'd0);
    check("arst_din_rdy", 64'(din_rdy), 64'd1);
    check("arst_quot", 64'(quot), 64'd0);
    check("arst_rem", 64'(rem), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("arst_no_stale_vld", 64'(dout_vld), 64'd0);
    start_op(42'd100, 4'd10);
    wait_done(lat);
    check("arst_next_latency", 64'(lat), 64'd43);
    check("arst_next_quot", 64'(quot), 64'd10);
    check("arst_next_rem", 64'(rem), 64'd0);
    tick();

    // Random operands against the model
    for (int k = 0; k < 20; k++) begin
      a = {10'($urandom), 32'($urandom)};
      b = 4'($urandom_range(0, 15));
      if (k % 4 == 0) a = a >> $urandom_range(0, 40);
      ref_div(a, b, eq, er);
      start_op(a, b);
      wait_done(lat);
      check($sformatf("rnd%0d_latency", k), 64'(lat), 64'd43);
      check($sformatf("rnd%0d_quot(%0d/%0d)", k, a, b), 64'(quot), 64'(eq));
      check($sformatf("rnd%0d_rem(%0d/%0d)", k, a, b), 64'(rem), 64'(er));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
